uart_cmd_wrapper: RTL and testbench

- Sits between the byte-level UART and the command processor.
- Assembles two received bytes, high byte first, into a 16-bit command and presents it with a cmd_rdy/clr_cmd_rdy handshake.
- Converts each send_resp pulse from the command processor into one UART transmit of a fixed acknowledge byte. Responses that arrive while the transmitter is busy are queued.
- Discards a stale high byte if the low byte does not follow within a timeout.

---
 rtl/uart_cmd_pkg.sv | 16 +
 rtl/uart_cmd_wrapper_resp_tx_ctrl.sv | 64 ++++++
 rtl/uart_cmd_wrapper.sv | 101 ++++++++++
 tb/tb_uart_cmd_wrapper.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command wrapper and its response transmitter.
package uart_cmd_pkg;

  typedef enum logic {
    RX_HIGH = 1'b0,
    RX_LOW  = 1'b1
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  localparam logic [7:0] ACK_BYTE = 8'hA5;

endpackage

// File: rtl/uart_cmd_wrapper_resp_tx_ctrl.sv
// Response transmitter: turns send_resp requests into trmt strobes, queuing up to three
// requests that arrive while a byte is still being sent.
module resp_tx_ctrl
  import uart_cmd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic send_resp,
  input  logic tx_done,
  output logic trmt
);

  tx_state_t   state;
  tx_state_t   state_next;
  logic [1:0]  pending;
  logic [1:0]  pending_next;
  logic [1:0]  pending_req;
  logic        trmt_next;

  // Count a same-cycle request before tx_done looks at the queue, so it is re-issued at once.
  assign pending_req = (send_resp && (pending != 2'd3)) ? pending + 2'd1 : pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      pending <= 2'd0;
      trmt    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      trmt    <= trmt_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE: if (send_resp) state_next = TX_BUSY;
      TX_BUSY: if (tx_done && (pending_req == 2'd0)) state_next = TX_IDLE;
      default: state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    trmt_next    = 1'b0;
    pending_next = pending;
    case (state)
      TX_IDLE: begin
        trmt_next    = send_resp;
        pending_next = 2'd0;
      end
      TX_BUSY: begin
        if (tx_done && (pending_req != 2'd0)) begin
          trmt_next    = 1'b1;
          pending_next = pending_req - 2'd1;
        end else begin
          pending_next = pending_req;
        end
      end
      default: pending_next = 2'd0;
    endcase
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two UART bytes (high first) into a 16-bit command with a ready/clear handshake,
// and sends a fixed acknowledge byte for every response request.
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] RESP_BYTE = ACK_BYTE,
  parameter int         TIMEOUT   = 50000,
  parameter int         TO_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        byte_to,
  output logic        cmd_ovr
);

  rx_state_t         rx_state;
  rx_state_t         rx_state_next;
  logic [7:0]        high_byte;
  logic [TO_W-1:0]   timer;
  logic              accept_high;
  logic              accept_low;
  logic              timed_out;

  assign accept_high = (rx_state == RX_HIGH) && rx_rdy;
  assign accept_low  = (rx_state == RX_LOW) && rx_rdy;
  // A low byte arriving on the last timer cycle wins over the timeout.
  assign timed_out   = (rx_state == RX_LOW) && !rx_rdy && (timer == TO_W'(TIMEOUT - 1));

  assign tx_data = RESP_BYTE;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_HIGH;
    else     rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_HIGH: if (rx_rdy) rx_state_next = RX_LOW;
      RX_LOW:  if (rx_rdy || timed_out) rx_state_next = RX_HIGH;
      default: rx_state_next = RX_HIGH;
    endcase
  end

  always_comb begin
    clr_rx_rdy = 1'b0;
    case (rx_state)
      RX_HIGH: clr_rx_rdy = rx_rdy;
      RX_LOW:  clr_rx_rdy = rx_rdy;
      default: clr_rx_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      high_byte <= 8'h00;
      timer     <= '0;
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
      byte_to   <= 1'b0;
      cmd_ovr   <= 1'b0;
    end else begin
      byte_to <= timed_out;
      cmd_ovr <= accept_low && cmd_rdy && !clr_cmd_rdy;
      if (accept_high) begin
        high_byte <= rx_data;
        timer     <= '0;
      end else if (timed_out) begin
        timer <= '0;
      end else if ((rx_state == RX_LOW) && !rx_rdy) begin
        timer <= timer + 1'b1;
      end
      // Completion takes priority over a same-cycle clear.
      if (accept_low) begin
        cmd     <= {high_byte, rx_data};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  resp_tx_ctrl u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .trmt      (trmt)
  );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper with a short inter-byte timeout.
module tb_uart_cmd_wrapper;
  import uart_cmd_pkg::*;

  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        byte_to;
  logic        cmd_ovr;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  int trmt_cnt = 0;
  int trmt_consec = 0;
  logic trmt_prev = 1'b0;

  uart_cmd_wrapper #(.RESP_BYTE(8'hA5), .TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .byte_to(byte_to), .cmd_ovr(cmd_ovr)
  );

  // Clock and trmt monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (trmt) begin
      trmt_cnt++;
      if (trmt_prev) trmt_consec++;
    end
    trmt_prev = trmt;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic clr);
    rx_rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = clr;
    #1;
    checks++;
    if (clr_rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL clr_rx_rdy byte %h: got %b want 1", b, clr_rx_rdy);
    end
    tick();
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_resp();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Scoreboard: pop one expected command once the completion edge has passed
  task automatic check_cmd(input string name);
    logic [15:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s queue: got empty want entry", name);
    end else begin
      exp = exp_q.pop_front();
      if (cmd_rdy !== 1'b1 || cmd !== exp) begin
        errors++;
        $display("FAIL %s cmd: got rdy=%b cmd=%h want rdy=1 cmd=%h", name, cmd_rdy, cmd, exp);
      end
    end
  endtask

  task automatic clear_cmd(input string name);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s clr_cmd_rdy: got %b want 0", name, cmd_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || trmt !== 1'b0 || byte_to !== 1'b0 ||
        cmd_ovr !== 1'b0 || clr_rx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h rdy=%b trmt=%b to=%b ovr=%b clr=%b want all 0",
               cmd, cmd_rdy, trmt, byte_to, cmd_ovr, clr_rx_rdy);
    end
    checks++;
    if (tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL reset_tx_data: got %h want a5", tx_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cmd_basic();
    drive_byte(8'h2C, 1'b0);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_half: got cmd_rdy=%b want 0", cmd_rdy);
    end
    repeat (9) tick();
    exp_q.push_back(16'h2C3F);
    drive_byte(8'h3F, 1'b0);
    check_cmd("basic");
    clear_cmd("basic");
    checks++;
    if (cmd !== 16'h2C3F) begin
      errors++;
      $display("FAIL basic_hold: got cmd=%h want 2c3f", cmd);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int pulse_at = -1;
    drive_byte(8'h40, 1'b0);
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (byte_to === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses at cycle %0d want 1 at %0d", pulses, pulse_at, TIMEOUT);
    end
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h2C3F) begin
      errors++;
      $display("FAIL timeout_cmd_kept: got rdy=%b cmd=%h want rdy=0 cmd=2c3f", cmd_rdy, cmd);
    end
    exp_q.push_back(16'h0001);
    drive_byte(8'h00, 1'b0);
    drive_byte(8'h01, 1'b0);
    check_cmd("after_timeout");
    clear_cmd("after_timeout");
    // Low byte lands exactly on the last timer cycle
    drive_byte(8'h12, 1'b0);
    repeat (TIMEOUT - 1) tick();
    exp_q.push_back(16'h1234);
    drive_byte(8'h34, 1'b0);
    checks++;
    if (byte_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge_byte_to: got %b want 0", byte_to);
    end
    check_cmd("timeout_edge");
    clear_cmd("timeout_edge");
  endtask

  task automatic test_overrun();
    exp_q.push_back(16'h5555);
    drive_byte(8'h55, 1'b0);
    drive_byte(8'h55, 1'b0);
    check_cmd("ovr_first");
    exp_q.push_back(16'h6000);
    drive_byte(8'h60, 1'b0);
    drive_byte(8'h00, 1'b0);
    checks++;
    if (cmd_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: got %b want 1", cmd_ovr);
    end
    check_cmd("ovr_second");
    tick();
    checks++;
    if (cmd_ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_one_cycle: got %b want 0", cmd_ovr);
    end
    exp_q.push_back(16'h6001);
    drive_byte(8'h60, 1'b0);
    drive_byte(8'h01, 1'b1);
    checks++;
    if (cmd_ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_with_clear: got %b want 0", cmd_ovr);
    end
    check_cmd("set_beats_clear");
    clear_cmd("overrun");
  endtask

  task automatic test_single_resp();
    int base = trmt_cnt;
    pulse_resp();
    checks++;
    if (trmt !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_trmt: got trmt=%b data=%h want trmt=1 data=a5", trmt, tx_data);
    end
    repeat (29) tick();
    pulse_done();
    tick();
    checks++;
    if (trmt_cnt - base != 1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", trmt_cnt - base);
    end
    checks++;
    if (dut.u_resp_tx.state !== TX_IDLE) begin
      errors++;
      $display("FAIL single_idle: got %0d want %0d", dut.u_resp_tx.state, TX_IDLE);
    end
  endtask

  task automatic test_pending_sat();
    int base = trmt_cnt;
    pulse_resp();
    tick();
    repeat (4) begin
      pulse_resp();
      tick();
    end
    for (int k = 1; k <= 4; k++) begin
      repeat (5) tick();
      pulse_done();
      checks++;
      if (trmt !== (k <= 3)) begin
        errors++;
        $display("FAIL pending_reissue_%0d: got trmt=%b want %b", k, trmt, (k <= 3));
      end
    end
    tick();
    checks++;
    if (trmt_cnt - base != 4) begin
      errors++;
      $display("FAIL pending_total: got %0d want 4", trmt_cnt - base);
    end
    checks++;
    if (dut.u_resp_tx.state !== TX_IDLE) begin
      errors++;
      $display("FAIL pending_idle: got %0d want %0d", dut.u_resp_tx.state, TX_IDLE);
    end
  endtask

  task automatic test_same_cycle();
    pulse_resp();
    repeat (3) tick();
    send_resp = 1'b1;
    tx_done = 1'b1;
    tick();
    send_resp = 1'b0;
    tx_done = 1'b0;
    checks++;
    if (trmt !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_reissue: got %b want 1", trmt);
    end
    repeat (3) tick();
    pulse_done();
    checks++;
    if (trmt !== 1'b0 || dut.u_resp_tx.state !== TX_IDLE) begin
      errors++;
      $display("FAIL same_cycle_finish: got trmt=%b state=%0d want trmt=0 state=%0d",
               trmt, dut.u_resp_tx.state, TX_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    exp_q.push_back(16'h7788);
    drive_byte(8'h77, 1'b0);
    drive_byte(8'h88, 1'b0);
    check_cmd("pre_reset");
    drive_byte(8'hAB, 1'b0);
    pulse_resp();
    tick();
    pulse_resp();
    base = trmt_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || trmt !== 1'b0 || byte_to !== 1'b0 || cmd_ovr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got cmd=%h rdy=%b trmt=%b to=%b ovr=%b want all 0",
               cmd, cmd_rdy, trmt, byte_to, cmd_ovr);
    end
    exp_q.push_back(16'hCDEF);
    drive_byte(8'hCD, 1'b0);
    drive_byte(8'hEF, 1'b0);
    check_cmd("post_reset");
    pulse_done();
    tick();
    checks++;
    if (trmt_cnt != base) begin
      errors++;
      $display("FAIL mid_reset_no_reissue: got %0d trmt want 0", trmt_cnt - base);
    end
    clear_cmd("post_reset");
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_timeout();
    test_overrun();
    test_single_resp();
    test_pending_sat();
    test_same_cycle();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    checks++;
    if (trmt_consec != 0) begin
      errors++;
      $display("FAIL trmt_back_to_back: got %0d want 0", trmt_consec);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
